branch_predict_tournament: RTL and testbench

Parametrised dynamic branch predictor for the 5-stage MIPS pipeline, the next generation after the fixed 2-bit-counter predictor. It supports bimodal, gshare or tournament mode selected by parameter, with configurable table depth, counter width and global-history length. It keeps a speculative global history register (GHR) with single-cycle recovery on mispredict. Lookup sits on the F/D boundary; update comes from the E/M stage where the branch resolves.

---
 rtl/branch_predict_tournament.sv | 132 +++++++++++++
 tb/tb_branch_predict_tournament.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_tournament.sv
// Bimodal / gshare / tournament branch predictor with a speculative global history
// register and single-cycle history recovery on mispredict.

module bptCntTable #(
   parameter int               IDX_W   = 10,
   parameter int               CNT_W   = 2,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rdIdx,
   output logic             rdMsb,
   input  logic             updEn,
   input  logic [IDX_W-1:0] updIdx,
   input  logic             updUp
);
   localparam int DEPTH = 1 << IDX_W;

   logic [CNT_W-1:0] ctr [DEPTH];

   // Saturating up/down counters; reads are combinational and see pre-update state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) ctr[i] <= RST_VAL;
      end else if (updEn) begin
         if (updUp && (ctr[updIdx] != '1))
            ctr[updIdx] <= ctr[updIdx] + CNT_W'(1);
         else if (!updUp && (ctr[updIdx] != '0))
            ctr[updIdx] <= ctr[updIdx] - CNT_W'(1);
      end
   end

   assign rdMsb = ctr[rdIdx][CNT_W-1];
endmodule

module branch_predict_tournament #(
   parameter int IDX_W = 10,
   parameter int GHR_W = 8,
   parameter int CNT_W = 2,
   parameter int MODE  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lookup_en,
   input  logic [31:0]      lookup_pc,
   output logic             pred_take,
   output logic [1:0]       pred_meta,
   output logic [GHR_W-1:0] pred_ghr,
   input  logic             upd_en,
   input  logic [31:0]      upd_pc,
   input  logic             upd_taken,
   input  logic [1:0]       upd_meta,
   input  logic [GHR_W-1:0] upd_ghr,
   input  logic             upd_mispredict,
   output logic [15:0]      mispredict_cnt
);
   localparam logic [CNT_W-1:0] CNT_RST = CNT_W'((1 << (CNT_W-1)) - 1);

   logic [GHR_W-1:0] ghr, ghrShift, ghrRecover;
   logic [IDX_W-1:0] lkBidx, lkGidx, upBidx, upGidx;
   logic             bimTake, gshTake, choGsh;
   logic             recover;
   logic             unusedBits;

   assign lkBidx  = lookup_pc[IDX_W+1:2];
   assign lkGidx  = lkBidx ^ IDX_W'(ghr);
   assign upBidx  = upd_pc[IDX_W+1:2];
   assign upGidx  = upBidx ^ IDX_W'(upd_ghr);
   assign recover = upd_en && upd_mispredict;

   if (MODE == 0 || MODE == 2) begin : gBim
      bptCntTable #(.IDX_W(IDX_W), .CNT_W(CNT_W), .RST_VAL(CNT_RST)) uBim (
         .clk(clk), .rst(rst), .rdIdx(lkBidx), .rdMsb(bimTake),
         .updEn(upd_en), .updIdx(upBidx), .updUp(upd_taken));
   end else begin : gNoBim
      assign bimTake = 1'b0;
   end

   if (MODE == 1 || MODE == 2) begin : gGsh
      bptCntTable #(.IDX_W(IDX_W), .CNT_W(CNT_W), .RST_VAL(CNT_RST)) uGsh (
         .clk(clk), .rst(rst), .rdIdx(lkGidx), .rdMsb(gshTake),
         .updEn(upd_en), .updIdx(upGidx), .updUp(upd_taken));
   end else begin : gNoGsh
      assign gshTake = 1'b0;
   end

   // Chooser only learns when the two components disagreed; it leans toward whichever was right.
   if (MODE == 2) begin : gCho
      bptCntTable #(.IDX_W(IDX_W), .CNT_W(2), .RST_VAL(2'b01)) uCho (
         .clk(clk), .rst(rst), .rdIdx(lkBidx), .rdMsb(choGsh),
         .updEn(upd_en && (upd_meta[1] != upd_meta[0])), .updIdx(upBidx),
         .updUp(upd_meta[1] == upd_taken));
   end else begin : gNoCho
      assign choGsh = 1'b0;
   end

   always_comb begin
      pred_take = bimTake;
      case (MODE)
         0:       pred_take = bimTake;
         1:       pred_take = gshTake;
         default: pred_take = choGsh ? gshTake : bimTake;
      endcase
   end

   assign pred_meta = {gshTake, bimTake};
   assign pred_ghr  = ghr;

   if (GHR_W == 1) begin : gGhr1
      assign ghrShift   = pred_take;
      assign ghrRecover = upd_taken;
   end else begin : gGhrN
      assign ghrShift   = {ghr[GHR_W-2:0], pred_take};
      assign ghrRecover = {upd_ghr[GHR_W-2:0], upd_taken};
   end

   // Recovery wins over a same-cycle lookup shift: that lookup is on the flushed path.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ghr            <= '0;
         mispredict_cnt <= '0;
      end else begin
         if (recover)        ghr <= ghrRecover;
         else if (lookup_en) ghr <= ghrShift;
         if (recover && (mispredict_cnt != 16'hFFFF))
            mispredict_cnt <= mispredict_cnt + 16'd1;
      end
   end

   assign unusedBits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0], upd_pc[31:IDX_W+2],
                         upd_pc[1:0], upd_meta, upd_ghr, lkGidx, upGidx, choGsh};
endmodule

// File: tb/tb_branch_predict_tournament.sv
// Drives bimodal, gshare and tournament instances from one stimulus stream and
// compares them against an array-based reference predictor.

module tb_branch_predict_tournament;
   localparam int CNT_W = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;
   localparam int HALF  = 1 << (CNT_W - 1);

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        lookup_en = 1'b0;
   logic [31:0] lookup_pc = 32'h0040_0000;
   logic        upd_en = 1'b0;
   logic [31:0] upd_pc = '0;
   logic        upd_taken = 1'b0;
   logic [1:0]  upd_meta = '0;
   logic [7:0]  upd_ghr = '0;
   logic        upd_mispredict = 1'b0;

   logic [2:0]        predTake;
   logic [2:0][1:0]   predMeta;
   logic [2:0][7:0]   predGhr;
   logic [2:0][15:0]  misCnt;

   int checks = 0;
   int failures = 0;

   int         bim [1024];
   int         gsh [1024];
   int         cho [1024];
   logic [7:0] mGhr [3];
   int         mCnt;

   always #5 clk = ~clk;

   for (genvar m = 0; m < 3; m++) begin : gDut
      branch_predict_tournament #(.IDX_W(10), .GHR_W(8), .CNT_W(CNT_W), .MODE(m)) dut (
         .clk(clk), .rst(rst),
         .lookup_en(lookup_en), .lookup_pc(lookup_pc),
         .pred_take(predTake[m]), .pred_meta(predMeta[m]), .pred_ghr(predGhr[m]),
         .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_meta(upd_meta),
         .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict), .mispredict_cnt(misCnt[m]));
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int satStep(input int c, input bit up, input int cmax);
      if (up) return (c >= cmax) ? cmax : c + 1;
      return (c <= 0) ? 0 : c - 1;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 1024; i++) begin
         bim[i] = HALF - 1;
         gsh[i] = HALF - 1;
         cho[i] = 1;
      end
      for (int m = 0; m < 3; m++) mGhr[m] = '0;
      mCnt = 0;
   endtask

   task automatic expPred(input int m, input logic [31:0] pc, output bit take, output logic [1:0] meta);
      int bi, gi;
      bit bT, gT;
      bi = int'(pc[11:2]);
      gi = bi ^ int'(mGhr[m]);
      bT = bim[bi] >= HALF;
      gT = gsh[gi] >= HALF;
      case (m)
         0:       begin take = bT; meta = {1'b0, bT}; end
         1:       begin take = gT; meta = {gT, 1'b0}; end
         default: begin take = (cho[bi] >= 2) ? gT : bT; meta = {gT, bT}; end
      endcase
   endtask

   task automatic checkAll(input string tag);
      bit take;
      logic [1:0] meta;
      for (int m = 0; m < 3; m++) begin
         expPred(m, lookup_pc, take, meta);
         chk($sformatf("%s.m%0d.take", tag, m), 32'(predTake[m]), 32'(take));
         chk($sformatf("%s.m%0d.meta", tag, m), 32'(predMeta[m]), 32'(meta));
         chk($sformatf("%s.m%0d.ghr", tag, m), 32'(predGhr[m]), 32'(mGhr[m]));
         chk($sformatf("%s.m%0d.cnt", tag, m), 32'(misCnt[m]), mCnt);
      end
   endtask

   // Entered just after a rising edge; returns just after the next one.
   task automatic step(input bit le, input logic [31:0] lpc, input bit ue, input logic [31:0] upc,
                       input bit ut, input logic [1:0] um, input logic [7:0] ug, input bit umis,
                       input bit doChk);
      bit take [3];
      logic [1:0] meta;
      int bi, gi;
      lookup_en = le; lookup_pc = lpc; upd_en = ue; upd_pc = upc;
      upd_taken = ut; upd_meta = um; upd_ghr = ug; upd_mispredict = umis;
      #2;
      if (doChk) checkAll("step");
      for (int m = 0; m < 3; m++) expPred(m, lpc, take[m], meta);
      @(posedge clk);
      if (ue) begin
         bi = int'(upc[11:2]);
         gi = bi ^ int'(ug);
         bim[bi] = satStep(bim[bi], ut, CMAX);
         gsh[gi] = satStep(gsh[gi], ut, CMAX);
         if (um[1] != um[0]) cho[bi] = satStep(cho[bi], um[1] == ut, 3);
         if (umis && mCnt < 65535) mCnt++;
      end
      for (int m = 0; m < 3; m++) begin
         if (ue && umis)  mGhr[m] = {ug[6:0], ut};
         else if (le)     mGhr[m] = {mGhr[m][6:0], take[m]};
      end
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input bit t, input logic [1:0] meta,
                      input logic [7:0] g, input bit mis);
      step(1'b0, 32'h0, 1'b1, pc, t, meta, g, mis, 1'b1);
   endtask

   task automatic look(input logic [31:0] pc);
      step(1'b1, pc, 1'b0, 32'h0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic peek(input logic [31:0] pc);
      lookup_en = 1'b0; upd_en = 1'b0; upd_mispredict = 1'b0; lookup_pc = pc;
      #1;
   endtask

   task automatic resetOutputsZero(input string tag);
      for (int m = 0; m < 3; m++) begin
         chk($sformatf("%s.m%0d.take", tag, m), 32'(predTake[m]), 32'd0);
         chk($sformatf("%s.m%0d.meta", tag, m), 32'(predMeta[m]), 32'd0);
         chk($sformatf("%s.m%0d.ghr", tag, m), 32'(predGhr[m]), 32'd0);
         chk($sformatf("%s.m%0d.cnt", tag, m), 32'(misCnt[m]), 32'd0);
      end
   endtask

   task automatic doReset();
      rst = 1'b0;
      #1;
      modelReset();
      resetOutputsZero("reset");
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      modelReset();
      // Reset values with a representative lookup PC
      lookup_pc = 32'h0040_0000;
      #12;
      resetOutputsZero("rst_init");
      rst = 1'b1;
      @(posedge clk);
      #1;
      look(32'h0040_0000);

      // Bimodal training and low saturation
      doReset();
      upd(32'h100, 1'b1, 2'b00, 8'h00, 1'b0);
      upd(32'h100, 1'b1, 2'b00, 8'h00, 1'b0);
      peek(32'h100);
      chk("bim_trained_taken", 32'(predTake[0]), 32'd1);
      repeat (3) upd(32'h100, 1'b0, 2'b00, 8'h00, 1'b0);
      peek(32'h100);
      chk("bim_trained_not", 32'(predTake[0]), 32'd0);
      upd(32'h100, 1'b0, 2'b00, 8'h00, 1'b0);
      upd(32'h100, 1'b1, 2'b00, 8'h00, 1'b0);
      peek(32'h100);
      chk("bim_sat_low", 32'(predTake[0]), 32'd0);

      // Gshare separates the same PC by history
      upd(32'h200, 1'b1, 2'b00, 8'h55, 1'b0);
      upd(32'h200, 1'b1, 2'b00, 8'h55, 1'b0);
      upd(32'h200, 1'b0, 2'b00, 8'hAA, 1'b0);
      upd(32'h200, 1'b0, 2'b00, 8'hAA, 1'b0);
      upd(32'h3F0, 1'b1, 2'b00, 8'h2A, 1'b1);
      peek(32'h200);
      chk("gsh_ghr55", 32'(predGhr[1]), 32'h55);
      chk("gsh_take55", 32'(predTake[1]), 32'd1);
      upd(32'h3F0, 1'b0, 2'b00, 8'h55, 1'b1);
      peek(32'h200);
      chk("gsh_ghrAA", 32'(predGhr[1]), 32'hAA);
      chk("gsh_takeAA", 32'(predTake[1]), 32'd0);

      // Speculative shift, then recovery overriding a same-cycle lookup
      doReset();
      upd(32'h300, 1'b1, 2'b00, 8'h00, 1'b0);
      upd(32'h300, 1'b1, 2'b00, 8'h00, 1'b0);
      look(32'h304);
      look(32'h300);
      look(32'h300);
      peek(32'h0);
      chk("spec_ghr011", 32'(predGhr[0]), 32'h3);
      step(1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 2'b00, 8'h01, 1'b1, 1'b1);
      peek(32'h0);
      for (int m = 0; m < 3; m++) chk($sformatf("recover_ghr.m%0d", m), 32'(predGhr[m]), 32'h2);
      chk("recover_cnt", 32'(misCnt[0]), 32'd1);

      // Tournament chooser moves only on disagreement
      doReset();
      upd(32'h400, 1'b1, 2'b10, 8'h0F, 1'b0);
      upd(32'h400, 1'b1, 2'b10, 8'h0F, 1'b0);
      peek(32'h400);
      chk("tour_sel_gsh", 32'(predTake[2]), 32'd0);
      chk("tour_meta", 32'(predMeta[2]), 32'h1);
      chk("tour_bim_only", 32'(predTake[0]), 32'd1);
      upd(32'h400, 1'b1, 2'b00, 8'h0F, 1'b0);
      upd(32'h400, 1'b1, 2'b00, 8'h0F, 1'b0);
      peek(32'h400);
      chk("tour_agree_hold", 32'(predTake[2]), 32'd0);

      // Randomized traffic over a small PC pool so entries collide and train
      doReset();
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 1)), 32'h0040_0000 + (32'($urandom_range(0, 15)) << 2),
              1'($urandom_range(0, 1)), 32'h0040_0000 + (32'($urandom_range(0, 15)) << 2),
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 7)),
              ($urandom_range(0, 3) == 0), 1'b1);
      end

      // Mispredict counter saturation
      for (int i = 0; i < 70000; i++)
         step(1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 2'b00, 8'hFF, 1'b1, 1'b0);
      peek(32'h0);
      for (int m = 0; m < 3; m++) chk($sformatf("cnt_sat.m%0d", m), 32'(misCnt[m]), 32'hFFFF);
      step(1'b1, 32'h0, 1'b1, 32'h0, 1'b1, 2'b00, 8'hFF, 1'b1, 1'b1);
      peek(32'h0);
      chk("cnt_hold", 32'(misCnt[2]), 32'hFFFF);
      chk("pre_rst_take", 32'(predTake[0]), 32'd1);

      // Asynchronous reset between edges
      rst = 1'b0;
      #1;
      resetOutputsZero("rst_mid");
      modelReset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      look(32'h0);
      look(32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
